// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types for the 8-way round-robin arbiter in front of the Mux8to1 selector.
// Contents: requester count, select width, request vector type, arbiter state enum.
// No ports; imported by rr_pick and mux8_rr_arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start_i, wrapping.
// Ports: req_i (request vector), start_i (first index searched) -> found_o, onehot_o, idx_o.
// Purely combinational, zero latency; no handshake.
module rr_pick
    import arb_pkg::*;
(
    input  req_vec_t         req_i,
    input  logic [SEL_W-1:0] start_i,
    output logic             found_o,
    output req_vec_t         onehot_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // SEL_W-bit addition wraps modulo NUM_REQ, giving the circular search order.
            cand = start_i + SEL_W'(k);
            if (!found_o && req_i[cand]) begin
                found_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the Mux8to1 select, with valid/ready handshake to one consumer.
// Ports: clk, reset (sync, active-high), req, out_ready -> grant (one-hot), select, out_valid, xfer_count.
// Grant registered 1 cycle after request; held while out_ready is low; back-to-back on accept.
module mux8_rr_arbiter
    import arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   select,
    output logic               out_valid,
    output logic [CNT_W-1:0]   xfer_count
);

    arb_state_t       state_q, state_d;
    req_vec_t         grant_q, grant_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    req_vec_t         pick_req;
    logic [SEL_W-1:0] pick_start;
    logic             pick_found;
    req_vec_t         pick_onehot;
    logic [SEL_W-1:0] pick_idx;

    // One picker serves both cases. While BUSY the only useful pick is the re-pick on
    // accept: the served requester is masked and the search starts just after it, which
    // equals the value last will take on this edge.
    always_comb begin
        if (state_q == BUSY) begin
            pick_req   = req & ~grant_q;
            pick_start = select_q + SEL_W'(1);
        end else begin
            pick_req   = req;
            pick_start = last_q + SEL_W'(1);
        end
    end

    rr_pick u_pick (
        .req_i    (pick_req),
        .start_i  (pick_start),
        .found_o  (pick_found),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        valid_d  = valid_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = BUSY;
                    grant_d  = pick_onehot;
                    select_d = pick_idx;
                    valid_d  = 1'b1;
                end
            end
            BUSY: begin
                // Without out_ready everything holds; req changes are deliberately ignored.
                if (out_ready) begin
                    last_d = select_q;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (pick_found) begin
                        grant_d  = pick_onehot;
                        select_d = pick_idx;
                    end else begin
                        // select keeps its value so the mux output stays stable while idle.
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            select_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= '1;     // index 7, so requester 0 is searched first after reset
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant      = grant_q;
    assign select     = select_q;
    assign out_valid  = valid_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter with a 4-bit transfer counter.
// Each scenario task queues expected {grant, select, out_valid, xfer_count} per cycle as it
// drives stimulus, then pops and compares one entry after every rising edge.
module tb_mux8_rr_arbiter;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [7:0]       g;
        logic [2:0]       s;
        logic             v;
        logic [CNT_W-1:0] c;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       req;
    logic             out_ready;
    logic [7:0]       grant;
    logic [2:0]       select;
    logic             out_valid;
    logic [CNT_W-1:0] xfer_count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .out_ready  (out_ready),
        .grant      (grant),
        .select     (select),
        .out_valid  (out_valid),
        .xfer_count (xfer_count)
    );

    function automatic exp_t mk(logic [7:0] g, int s, logic v, int c);
        exp_t e;
        e.g = g;
        e.s = s[2:0];
        e.v = v;
        e.c = c[CNT_W-1:0];
        return e;
    endfunction

    task automatic apply_reset();
        reset = 1'b1; req = 8'h00; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Reset held 2 cycles with all requests up, then first grant goes to requester 0.
    task automatic test_reset();
        exp_t e;
        reset = 1'b1; req = 8'hFF; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) reset = 1'b0;
            exp_q.push_back(i < 2 ? mk(8'h00, 0, 1'b0, 0) : mk(8'h01, 0, 1'b1, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({grant, select, out_valid, xfer_count} !== e) begin
                errors++;
                $display("FAIL reset cyc%0d got g=%h s=%0d v=%b c=%0d want g=%h s=%0d v=%b c=%0d",
                         i, grant, select, out_valid, xfer_count, e.g, e.s, e.v, e.c);
            end
        end
    endtask

    // Continues from test_reset (grant 0 held): 16 accepts rotate 1..7,0..7,0.
    task automatic test_rotation();
        exp_t e;
        req = 8'hFF; out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            exp_q.push_back(mk(8'h01 << (k % 8), k % 8, 1'b1, k));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({grant, select, out_valid, xfer_count} !== e) begin
                errors++;
                $display("FAIL rotation k%0d got g=%h s=%0d v=%b c=%0d want g=%h s=%0d v=%b c=%0d",
                         k, grant, select, out_valid, xfer_count, e.g, e.s, e.v, e.c);
            end
        end
        out_ready = 1'b0;
    endtask

    // Stall holds grant 04 even when req[0] appears; accepts then give 20, 01, idle.
    task automatic test_backpressure();
        exp_t       e;
        logic [7:0] rq [8] = '{8'h24, 8'h24, 8'h25, 8'h25, 8'h25, 8'h25, 8'h21, 8'h01};
        logic       rd [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            req = rq[i]; out_ready = rd[i];
            if (i < 5)       exp_q.push_back(mk(8'h04, 2, 1'b1, 0));
            else if (i == 5) exp_q.push_back(mk(8'h20, 5, 1'b1, 1));
            else if (i == 6) exp_q.push_back(mk(8'h01, 0, 1'b1, 2));
            else             exp_q.push_back(mk(8'h00, 0, 1'b0, 3));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({grant, select, out_valid, xfer_count} !== e) begin
                errors++;
                $display("FAIL backpressure cyc%0d got g=%h s=%0d v=%b c=%0d want g=%h s=%0d v=%b c=%0d",
                         i, grant, select, out_valid, xfer_count, e.g, e.s, e.v, e.c);
            end
        end
    endtask

    // Lone requester 3 is masked after each transfer: valid alternates, select stays 3.
    task automatic test_single_mask();
        exp_t e;
        apply_reset();
        req = 8'h08; out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k % 2 == 1) exp_q.push_back(mk(8'h08, 3, 1'b1, (k - 1) / 2));
            else            exp_q.push_back(mk(8'h00, 3, 1'b0, k / 2));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({grant, select, out_valid, xfer_count} !== e) begin
                errors++;
                $display("FAIL single_mask k%0d got g=%h s=%0d v=%b c=%0d want g=%h s=%0d v=%b c=%0d",
                         k, grant, select, out_valid, xfer_count, e.g, e.s, e.v, e.c);
            end
        end
    endtask

    // Reset while requester 6 is stalled drops the transfer; afterwards 8'hC0 grants 6 again.
    task automatic test_mid_reset();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            reset     = (i == 2);
            req       = (i == 3) ? 8'hC0 : 8'h40;
            exp_q.push_back(i == 2 ? mk(8'h00, 0, 1'b0, 0) : mk(8'h40, 6, 1'b1, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({grant, select, out_valid, xfer_count} !== e) begin
                errors++;
                $display("FAIL mid_reset cyc%0d got g=%h s=%0d v=%b c=%0d want g=%h s=%0d v=%b c=%0d",
                         i, grant, select, out_valid, xfer_count, e.g, e.s, e.v, e.c);
            end
        end
        reset = 1'b0;
    endtask

    // From idle: first edge grants 0, then 17 back-to-back accepts wrap the 4-bit count to 1.
    task automatic test_back_to_back_wrap();
        exp_t e;
        apply_reset();
        req = 8'hFF; out_ready = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            exp_q.push_back(mk(8'h01 << ((k - 1) % 8), (k - 1) % 8, 1'b1, (k - 1) % 16));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({grant, select, out_valid, xfer_count} !== e) begin
                errors++;
                $display("FAIL wrap k%0d got g=%h s=%0d v=%b c=%0d want g=%h s=%0d v=%b c=%0d",
                         k, grant, select, out_valid, xfer_count, e.g, e.s, e.v, e.c);
            end
        end
        checks++;
        if (xfer_count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_final got c=%0d want c=1", xfer_count);
        end
    endtask

    initial begin
        reset = 1'b1; req = 8'h00; out_ready = 1'b0;
        #2;
        test_reset();
        test_rotation();
        test_backpressure();
        test_single_mask();
        test_mid_reset();
        test_back_to_back_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares the 8-input, 32-bit `Mux8to1` selector between eight requesters feeding one downstream consumer. It owns the mux `select`, issues a one-hot grant, and runs a valid/ready handshake toward the consumer. The grant is held until the consumer accepts the transfer. The block sits between the requesting pipeline units (data0..data7 sources) and the shared result bus; its `select` output drives the `Mux8to1` instance directly.

## Interface

**Parameters**
- `NUM_REQ`, 8: number of requesters. Fixed at 8 to match `Mux8to1`.
- `SEL_W`, 3: select width, equal to log2(`NUM_REQ`).
- `CNT_W`, 16: width of the accepted-transfer counter.

**Ports**
- `clk`, in, 1: single clock, rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 8: per-requester request, level-sensitive. A requester holds its bit high until its transfer is accepted.
- `out_ready`, in, 1: consumer can accept the muxed word this cycle.
- `grant`, out, 8: one-hot current grant, registered; all zeros when idle.
- `select`, out, 3: binary index of the granted requester, routed to `Mux8to1.select`. Registered.
- `out_valid`, out, 1: the muxed result is valid for the consumer. Registered.
- `xfer_count`, out, `CNT_W`: number of accepted transfers since reset, wrapping.

## Operation

- Two states: `IDLE` and `BUSY`. Reset state is `IDLE`.
- **Reset values:** `grant`=0, `select`=0, `out_valid`=0, `xfer_count`=0, round-robin pointer `last`=7. With `last`=7, requester 0 has top priority after reset.
- **Priority:** search starts at index (`last`+1) mod 8 and ascends with wrap-around. The first set `req` bit wins.
- **IDLE:** if any `req` bit is set, go to `BUSY`. Register `grant`, `select` and `out_valid`=1 for the winner. Otherwise stay in `IDLE`.
- **BUSY, out_ready=0:** hold `grant`, `select` and `out_valid`. Changes on `req` are ignored, including withdrawal (a protocol violation) and new higher-priority requests.
- **BUSY, out_ready=1 (accept):**
  - `last` := `select`.
  - `xfer_count` increments.
  - Re-arbitrate in the same cycle over `req` with the just-served bit masked.
  - If a winner exists, stay in `BUSY` and load the new grant, giving back-to-back transfers.
  - If none, go to `IDLE` with `grant`=0 and `out_valid`=0.
- **Masking rule:** a requester never receives two consecutive grants. It re-arbitrates normally one cycle later.
- **`xfer_count`:** wraps from 2^`CNT_W`−1 to 0 with no saturation.
- **`reset` mid-transfer:** all outputs return to reset values on the next edge. The in-flight transfer is dropped and not counted.
- **`select` when idle:** holds its last value, so the mux output is stable. Only `out_valid` qualifies it.

## Timing

- **Request to grant:** 1 cycle. `req` high at edge n (state `IDLE`) gives `grant`/`out_valid` high after edge n.
- **Accept:** the handshake completes on a rising edge with `out_valid && out_ready`. The next grant is visible immediately after that edge.
- **Throughput:** 1 transfer/cycle while at least two requesters are active.
- **Fairness:** with all 8 requesting and `out_ready` tied high, the grant sequence is 0,1,…,7,0,… Maximum wait is 7 transfers.
- **Outputs:** all outputs are registered. There is no combinational path from `req`/`out_ready` to any output.

## Structure

- **Shared package `arb_pkg`:**
  - `NUM_REQ`, `SEL_W`.
  - `typedef logic [NUM_REQ-1:0] req_vec_t`.
  - `typedef enum logic {IDLE, BUSY} arb_state_t`.
- **Sub-module `rr_pick`:** combinational. Takes `req_vec_t` plus a start index and returns a found flag, a one-hot vector and a binary index. It is used for both the `IDLE` pick and the masked re-pick.
- **Top level:** `mux8_rr_arbiter` holds the state register, `last`, the output registers and the counter.

## Test plan

1. **Reset:** assert `reset` for 2 cycles with `req`=8'hFF. Expect `grant`=0, `out_valid`=0, `xfer_count`=0. After release, the first grant is 8'h01, `select`=0.
2. **Full rotation:** `req`=8'hFF and `out_ready`=1 for 16 cycles. Expect `select` sequence 0..7,0..7 and `xfer_count`=16.
3. **Backpressure hold:** `req`=8'h24, `out_ready`=0 for 5 cycles. Expect `grant`=8'h04 held. During the stall, raise `req[0]`; the grant must not change. Raise `out_ready`: next grant is 8'h20, then 8'h01.
4. **Single requester masking:** `req`=8'h08 constant, `out_ready`=1. Expect grants alternating 8'h08 and idle (`out_valid` 1,0,1,0), and `xfer_count` incrementing every other cycle.
5. **Mid-transfer reset:** grant to requester 6 with `out_ready`=0, then pulse `reset`. Expect all outputs zero and `xfer_count` unchanged at 0. With `req`=8'hC0 afterwards, the first grant is 8'h40.
6. **Counter wrap:** with `CNT_W`=4, perform 17 accepts. Expect `xfer_count`=1.
